// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// state enum, opcodes, datapath select encodings and the per-state control decode.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB,
      S_LUI, S_AUIPC, S_ILLEGAL
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       pc_write;
      logic       reg_write;
      logic       instret;
      logic       trap;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctl_t;

   // Unconditional Moore controls only; handshake- and branch-qualified
   // strobes are added at the top level.
   function automatic ctl_t state_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
         S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
         S_MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
         S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         S_MEMWB:    begin c.result_src = RES_RDATA; c.reg_write = 1'b1; c.instret = 1'b1; end
         S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
         S_EXECR:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_FUNCT; end
         S_EXECI:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
         S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.instret = 1'b1; end
         S_BRANCH:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_SUB; c.instret = 1'b1; end
         S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_write = 1'b1; end
         S_JALR:     begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.result_src = RES_ALURES; c.pc_write = 1'b1; end
         S_JALWB:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES;
                           c.reg_write = 1'b1; c.instret = 1'b1; end
         S_LUI:      begin c.alu_src_a = SRCA_ZERO; c.alu_src_b = SRCB_IMM; end
         S_AUIPC:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
         S_ILLEGAL:  c.trap = 1'b1;
         default:    c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_SW:           return IMM_S;
         OP_BR:           return IMM_B;
         OP_JAL:          return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:         return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory access handshake between the control unit (master) and the memory port (slave).
interface multicycle_control_fsm_if;
   // mem_req is held, with adr_src and mem_write stable, until a cycle in which
   // mem_ready is 1; that cycle completes the access. mem_ready is ignored
   // whenever mem_req is 0.
   logic mem_req;
   logic mem_write;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_branch_cond.sv
// RV32I branch condition resolver; also flags funct3 codes this build does not support.
module branch_cond #(
   parameter bit BRANCH_FULL = 1'b1
) (
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken,
   output logic       valid
);

   always_comb begin
      taken = 1'b0;
      valid = 1'b0;
      case (funct3)
         3'b000: begin taken = zero;  valid = 1'b1;        end
         3'b001: begin taken = !zero; valid = BRANCH_FULL; end
         3'b100: begin taken = lt;    valid = BRANCH_FULL; end
         3'b101: begin taken = !lt;   valid = BRANCH_FULL; end
         3'b110: begin taken = ltu;   valid = BRANCH_FULL; end
         3'b111: begin taken = !ltu;  valid = BRANCH_FULL; end
         default: begin taken = 1'b0; valid = 1'b0;        end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory handshake and traps on illegal opcodes.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter bit BRANCH_FULL   = 1'b1,
   parameter bit UTYPE_EN      = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [6:0]                op,
   input  logic [2:0]                funct3,
   input  logic                      zero,
   input  logic                      lt,
   input  logic                      ltu,
   multicycle_control_fsm_if.master  mem,
   output logic                      ir_write,
   output logic                      pc_write,
   output logic                      reg_write,
   output logic [1:0]                result_src,
   output logic [1:0]                alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                alu_op,
   output logic [2:0]                imm_src,
   output logic                      instret,
   output logic                      trap,
   output state_t                    state
);

   state_t state_q;
   state_t state_nxt;
   ctl_t   ctl_q;
   logic   ready;
   logic   br_taken;
   logic   br_valid;

   assign ready = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;

   branch_cond #(.BRANCH_FULL(BRANCH_FULL)) u_branch_cond (
      .funct3 (funct3),
      .zero   (zero),
      .lt     (lt),
      .ltu    (ltu),
      .taken  (br_taken),
      .valid  (br_valid)
   );

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_FETCH:    if (ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_R:         state_nxt = S_EXECR;
               OP_I:         state_nxt = S_EXECI;
               OP_BR:        state_nxt = br_valid ? S_BRANCH : S_ILLEGAL;
               OP_JAL:       state_nxt = S_JAL;
               OP_JALR:      state_nxt = S_JALR;
               OP_LUI:       state_nxt = UTYPE_EN ? S_LUI : S_ILLEGAL;
               OP_AUIPC:     state_nxt = UTYPE_EN ? S_AUIPC : S_ILLEGAL;
               default:      state_nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (ready) state_nxt = S_MEMWB;
         S_MEMWRITE: if (ready) state_nxt = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JALWB: state_nxt = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_nxt = S_ALUWB;
         S_JALR:     state_nxt = S_JALWB;
         S_ILLEGAL:  state_nxt = S_ILLEGAL;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // Controls are registered from the next state so they change only on the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctl_q   <= state_ctl(S_FETCH);
      end else begin
         state_q <= state_nxt;
         ctl_q   <= state_ctl(state_nxt);
      end
   end

   assign mem.mem_req   = ctl_q.mem_req & ~reset;
   assign mem.mem_write = ctl_q.mem_write & ~reset;
   assign mem.adr_src   = ctl_q.adr_src;

   assign ir_write  = ~reset & (state_q == S_FETCH) & ready;
   assign pc_write  = ~reset & (ctl_q.pc_write
                                | ((state_q == S_FETCH) & ready)
                                | ((state_q == S_BRANCH) & br_taken));
   assign reg_write = ~reset & ctl_q.reg_write;
   assign instret   = ~reset & (ctl_q.instret | ((state_q == S_MEMWRITE) & ready));
   assign trap      = ~reset & ctl_q.trap;

   assign result_src = ctl_q.result_src;
   assign alu_src_a  = ctl_q.alu_src_a;
   assign alu_src_b  = ctl_q.alu_src_b;
   assign alu_op     = ctl_q.alu_op;
   assign imm_src    = imm_sel(op);
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: full-featured instance plus a
// BRANCH_FULL=0 instance sharing the same instruction inputs.
module tb_multicycle_control_fsm;
   import riscv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero, lt, ltu, mem_ready;

   logic       ir_write, pc_write, reg_write, instret, trap;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0] imm_src;
   state_t     state;

   logic       b_ir_write, b_pc_write, b_reg_write, b_instret, b_trap;
   logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
   logic [2:0] b_imm_src;
   state_t     b_state;

   int checks = 0;
   int errors = 0;
   int ret_cnt = 0;
   int ir_cnt = 0;
   int ret0, ir0;

   multicycle_control_fsm_if m_if ();
   multicycle_control_fsm_if b_if ();
   assign m_if.mem_ready = mem_ready;
   assign b_if.mem_ready = mem_ready;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
      .mem(m_if.master), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_src(imm_src), .instret(instret), .trap(trap), .state(state)
   );

   multicycle_control_fsm #(.BRANCH_FULL(1'b0)) dut_beq (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
      .mem(b_if.master), .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
      .result_src(b_result_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
      .imm_src(b_imm_src), .instret(b_instret), .trap(b_trap), .state(b_state)
   );

   always @(negedge clk) begin
      if (instret === 1'b1) ret_cnt <= ret_cnt + 1;
      if (ir_write === 1'b1) ir_cnt <= ir_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic l, input logic lu, input logic exp_taken);
      op = OP_BR; funct3 = f3; zero = z; lt = l; ltu = lu; #1;
      chk($sformatf("%s_fetch_irw", tag), ir_write, 1'b1);
      tick();
      chk($sformatf("%s_dec_imm", tag), imm_src, IMM_B);
      tick();
      chk($sformatf("%s_br_state", tag), state, S_BRANCH);
      chk($sformatf("%s_br_pcw", tag), pc_write, exp_taken);
      chk($sformatf("%s_br_aluop", tag), alu_op, ALU_SUB);
      chk($sformatf("%s_br_instret", tag), instret, 1'b1);
      tick();
      chk($sformatf("%s_done_state", tag), state, S_FETCH);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      reset = 1'b1; op = 7'h00; funct3 = 3'b000; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
      tick();
      chk("rst_state", state, S_FETCH);
      chk("rst_mem_req", m_if.mem_req, 1'b0);
      chk("rst_ir_write", ir_write, 1'b0);
      chk("rst_trap", trap, 1'b0);
      chk("rst_instret", instret, 1'b0);
      reset = 1'b0; #1;
      chk("stall_mem_req", m_if.mem_req, 1'b1);
      chk("stall_ir_write", ir_write, 1'b0);

      // lw, no wait states: 5 cycles
      ret0 = ret_cnt;
      op = OP_LW; mem_ready = 1'b1; #1;
      chk("lw_f_state", state, S_FETCH);
      chk("lw_f_irw", ir_write, 1'b1);
      chk("lw_f_pcw", pc_write, 1'b1);
      chk("lw_f_srcb", alu_src_b, SRCB_FOUR);
      chk("lw_f_res", result_src, RES_ALURES);
      tick();
      chk("lw_d_state", state, S_DECODE);
      chk("lw_d_srca", alu_src_a, SRCA_OLDPC);
      chk("lw_d_srcb", alu_src_b, SRCB_IMM);
      chk("lw_d_imm", imm_src, IMM_I);
      chk("lw_d_req", m_if.mem_req, 1'b0);
      chk("lw_d_irw", ir_write, 1'b0);
      tick();
      chk("lw_ma_state", state, S_MEMADR);
      chk("lw_ma_srca", alu_src_a, SRCA_RS1);
      tick();
      chk("lw_mr_state", state, S_MEMREAD);
      chk("lw_mr_req", m_if.mem_req, 1'b1);
      chk("lw_mr_adr", m_if.adr_src, 1'b1);
      tick();
      chk("lw_wb_state", state, S_MEMWB);
      chk("lw_wb_regw", reg_write, 1'b1);
      chk("lw_wb_res", result_src, RES_RDATA);
      chk("lw_wb_instret", instret, 1'b1);
      tick();
      chk("lw_done_state", state, S_FETCH);
      chk("lw_instret_cnt", ret_cnt - ret0, 1);

      // sw with two wait states in MEMWRITE: 6 cycles
      ret0 = ret_cnt;
      op = OP_SW; #1;
      chk("sw_f_irw", ir_write, 1'b1);
      tick();
      chk("sw_d_imm", imm_src, IMM_S);
      tick();
      chk("sw_ma_state", state, S_MEMADR);
      tick();
      mem_ready = 1'b0; #1;
      chk("sw_w1_state", state, S_MEMWRITE);
      chk("sw_w1_memw", m_if.mem_write, 1'b1);
      chk("sw_w1_instret", instret, 1'b0);
      chk("sw_w1_regw", reg_write, 1'b0);
      tick();
      chk("sw_w2_state", state, S_MEMWRITE);
      chk("sw_w2_memw", m_if.mem_write, 1'b1);
      chk("sw_w2_adr", m_if.adr_src, 1'b1);
      tick();
      mem_ready = 1'b1; #1;
      chk("sw_w3_memw", m_if.mem_write, 1'b1);
      chk("sw_w3_instret", instret, 1'b1);
      chk("sw_w3_regw", reg_write, 1'b0);
      tick();
      chk("sw_done_state", state, S_FETCH);
      chk("sw_done_memw", m_if.mem_write, 1'b0);
      chk("sw_instret_cnt", ret_cnt - ret0, 1);

      run_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
      run_branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
      run_branch("bge_lt0", 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
      run_branch("bltu_lu0", 3'b110, 1'b0, 1'b1, 1'b0, 1'b0);
      run_branch("bgeu_lu1", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);

      // jalr
      op = OP_JALR; #1;
      tick();
      tick();
      chk("jalr_state", state, S_JALR);
      chk("jalr_pcw", pc_write, 1'b1);
      chk("jalr_res", result_src, RES_ALURES);
      chk("jalr_srca", alu_src_a, SRCA_RS1);
      chk("jalr_srcb", alu_src_b, SRCB_IMM);
      chk("jalr_regw", reg_write, 1'b0);
      tick();
      chk("jalwb_state", state, S_JALWB);
      chk("jalwb_regw", reg_write, 1'b1);
      chk("jalwb_srca", alu_src_a, SRCA_OLDPC);
      chk("jalwb_srcb", alu_src_b, SRCB_FOUR);
      chk("jalwb_instret", instret, 1'b1);
      tick();
      chk("jalr_done_state", state, S_FETCH);

      // reserved branch funct3 traps even with the full branch set
      op = OP_BR; funct3 = 3'b010; #1;
      tick();
      chk("f3_010_dec_trap", trap, 1'b0);
      tick();
      chk("f3_010_state", state, S_ILLEGAL);
      chk("f3_010_trap", trap, 1'b1);
      chk("f3_010_instret", instret, 1'b0);
      reset = 1'b1; #1;
      chk("f3_010_rst_trap", trap, 1'b0);
      tick();
      reset = 1'b0; #1;
      chk("f3_010_rel_state", state, S_FETCH);

      // blt on the beq-only build traps; full build takes it
      op = OP_BR; funct3 = 3'b100; lt = 1'b1; zero = 1'b0; #1;
      tick();
      chk("blt_b_dec_state", b_state, S_DECODE);
      chk("blt_b_dec_trap", b_trap, 1'b0);
      tick();
      chk("blt_b_state", b_state, S_ILLEGAL);
      chk("blt_b_trap", b_trap, 1'b1);
      chk("blt_full_state", state, S_BRANCH);
      chk("blt_full_pcw", pc_write, 1'b1);
      tick();
      chk("blt_b_trap_hold", b_trap, 1'b1);
      chk("blt_full_done", state, S_FETCH);

      // illegal opcode holds with no enables, even with mem_ready toggling
      op = 7'h7f; lt = 1'b0; #1;
      tick();
      tick();
      ret0 = ret_cnt;
      for (int i = 0; i < 10; i++) begin
         mem_ready = (i % 2 == 0); #1;
         chk($sformatf("ill_trap_%0d", i), trap, 1'b1);
         chk($sformatf("ill_req_%0d", i), m_if.mem_req, 1'b0);
         chk($sformatf("ill_irw_%0d", i), ir_write, 1'b0);
         chk($sformatf("ill_pcw_%0d", i), pc_write, 1'b0);
         chk($sformatf("ill_regw_%0d", i), reg_write, 1'b0);
         tick();
      end
      chk("ill_state", state, S_ILLEGAL);
      chk("ill_instret_cnt", ret_cnt - ret0, 0);
      reset = 1'b1; #1;
      chk("ill_rst_trap", trap, 1'b0);
      tick();
      reset = 1'b0; mem_ready = 1'b0; #1;
      chk("ill_rel_state", state, S_FETCH);
      chk("ill_rel_trap", trap, 1'b0);
      chk("ill_rel_b_trap", b_trap, 1'b0);

      // reset during a FETCH stall, then an R-type completes
      op = OP_R; ir0 = ir_cnt;
      tick();
      chk("rs_stall_state", state, S_FETCH);
      chk("rs_stall_irw", ir_write, 1'b0);
      chk("rs_stall_req", m_if.mem_req, 1'b1);
      reset = 1'b1; #1;
      chk("rs_rst_req", m_if.mem_req, 1'b0);
      chk("rs_rst_irw", ir_write, 1'b0);
      tick();
      mem_ready = 1'b1; #1;
      chk("rs_rst_rdy_irw", ir_write, 1'b0);
      chk("rs_rst_rdy_pcw", pc_write, 1'b0);
      chk("rs_rst_rdy_req", m_if.mem_req, 1'b0);
      tick();
      reset = 1'b0; mem_ready = 1'b0; #1;
      chk("rs_rel_state", state, S_FETCH);
      chk("rs_rel_irw", ir_write, 1'b0);
      chk("rs_rel_req", m_if.mem_req, 1'b1);
      tick();
      mem_ready = 1'b1; #1;
      chk("rs_go_irw", ir_write, 1'b1);
      tick();
      chk("rs_dec_state", state, S_DECODE);
      chk("rs_dec_irw", ir_write, 1'b0);
      chk("rs_ir_cnt", ir_cnt - ir0, 1);
      tick();
      chk("r_exec_state", state, S_EXECR);
      chk("r_exec_aluop", alu_op, ALU_FUNCT);
      chk("r_exec_srca", alu_src_a, SRCA_RS1);
      chk("r_exec_srcb", alu_src_b, SRCB_RS2);
      tick();
      chk("r_wb_state", state, S_ALUWB);
      chk("r_wb_regw", reg_write, 1'b1);
      chk("r_wb_res", result_src, RES_ALUOUT);
      chk("r_wb_instret", instret, 1'b1);
      tick();
      chk("r_done_state", state, S_FETCH);

      // lui
      op = OP_LUI; #1;
      chk("lui_imm", imm_src, IMM_U);
      tick();
      tick();
      chk("lui_state", state, S_LUI);
      chk("lui_srca", alu_src_a, SRCA_ZERO);
      chk("lui_srcb", alu_src_b, SRCB_IMM);
      tick();
      chk("lui_wb_state", state, S_ALUWB);
      tick();
      chk("lui_done_state", state, S_FETCH);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Control unit for the multi-cycle RV32I datapath. It replaces the one-shot opcode decode with a state machine that sequences each instruction as fetch, decode, execute, memory and writeback over several cycles. It stalls on a ready/request memory handshake and resolves all six RV32I branch conditions. Illegal opcodes trap and hold. It sits between the instruction register and the shared ALU/memory datapath.

## Interface
Parameters:
- BRANCH_FULL, 1: 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq only, other funct3 trap as illegal.
- UTYPE_EN, 1: 1 = lui/auipc supported; 0 = those opcodes trap.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  7  opcode from instruction register, valid from DECODE onward
- funct3  in  3  instruction funct3
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access active
- mem_write  out  1  store strobe
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register and OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct decode
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from op
- instret  out  1  one-cycle pulse in the final state of each instruction
- trap  out  1  illegal instruction, sticky

## Operation
- All outputs are a Moore decode of the state register, except three signals:
  - fetch-qualified ir_write/pc_write;
  - branch pc_write;
  - imm_src.
- While reset is high, mem_req, mem_write, ir_write, pc_write, reg_write, instret and trap are forced to 0. The next state is FETCH.
- Unlisted select outputs are 0 in every state.
- Per-state outputs and transitions:
  - FETCH: mem_req, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write fire only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
  - DECODE: a=01, b=01, alu_op=00 (branch/jal target into ALUOut). Next state by op:
    - lw → MEMADR
    - sw → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - jal → JAL
    - jalr → JALR
    - lui → LUI
    - auipc → AUIPC
    - anything else → ILLEGAL
  - MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: mem_req, adr_src=1. Wait for mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write, instret → FETCH.
  - MEMWRITE: mem_req, mem_write, adr_src=1. mem_write stays asserted until mem_ready. Then instret → FETCH.
  - EXECR: a=10, b=00, alu_op=10 → ALUWB.
  - EXECI: a=10, b=01, alu_op=10 → ALUWB.
  - ALUWB: result_src=00, reg_write, instret → FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, instret → FETCH. pc_write = taken, where:
    - funct3 000: zero
    - 001: !zero
    - 100: lt
    - 101: !lt
    - 110: ltu
    - 111: !ltu
    - funct3 010/011, and non-beq funct3 when BRANCH_FULL=0, go to ILLEGAL from DECODE.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write → ALUWB (rd ← OldPC+4).
  - JALR: a=10, b=01, alu_op=00, result_src=10, pc_write → JALWB.
  - JALWB: a=01, b=10, alu_op=00, result_src=10, reg_write, instret → FETCH.
  - LUI: a=11, b=01, alu_op=00 → ALUWB.
  - AUIPC: a=01, b=01, alu_op=00 → ALUWB.
  - ILLEGAL: all enables 0, trap=1. Held until reset.

## Timing
- Cycles per instruction with zero wait states:
  - lw: 5
  - sw: 4
  - R-type, I-ALU, jal, jalr, lui, auipc: 4
  - branch: 3
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held stable while stalled.
- mem_ready asserted outside a memory state is ignored.
- A reset high in any cycle, including mid-stall or in ILLEGAL, puts the FSM in FETCH on the next edge, with trap cleared.
- instret pulses exactly once per retired instruction and never for a trapped instruction.

## Structure
- Package riscv_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - result_src, alu_src_a, alu_src_b, alu_op and imm_src encodings.
- Sub-module branch_cond: funct3, zero, lt, ltu, BRANCH_FULL → taken, valid. It is shared with a future pipelined branch unit.

## Test plan
- lw with mem_ready tied 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles; reg_write and result_src=01 in cycle 5; one instret.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_write held 3 cycles, instruction takes 6 cycles, reg_write never asserted.
- bne (funct3=001) with zero=1 → pc_write=0 in BRANCH; repeat with zero=0 → pc_write=1; blt with BRANCH_FULL=0 → trap=1 from the following cycle.
- jalr → JALR cycle: pc_write=1, result_src=10, a=10, b=01; JALWB cycle: reg_write=1, a=01, b=10.
- op=7'b1111111 → ILLEGAL with trap held for 10 cycles and no enables; reset pulse → FETCH, trap=0.
- reset asserted during a FETCH stall (mem_ready=0) → all enables 0 while reset is high; FETCH resumes and a later mem_ready=1 produces a single ir_write.
